// File: rtl/load_store_unit_pkg.sv
// Shared definitions for the load/store unit: memory access modes, RV32I
// load/store funct3 encodings, FSM state type and the request legality check.
package load_store_unit_pkg;

  // Access size codes understood by the data memory (addrUnit)
  localparam logic [1:0] BYTE_MEMORY_MODE     = 2'b00;
  localparam logic [1:0] HALFWORD_MEMORY_MODE = 2'b01;
  localparam logic [1:0] WORD_MEMORY_MODE     = 2'b10;

  // RV32I load funct3
  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  // RV32I store funct3
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  typedef enum logic [1:0] {
    LSU_IDLE    = 2'b00,
    LSU_ACCESS  = 2'b01,
    LSU_CAPTURE = 2'b10,
    LSU_DONE    = 2'b11
  } lsu_state_t;

  // A request is rejected for an unused funct3, a store with the unsigned bit
  // set, or an address not aligned to its access size.
  function automatic logic lsu_req_error(input logic       store,
                                         input logic [2:0] funct3,
                                         input logic [1:0] addr_lo);
    logic bad_f3;
    logic misaligned;
    bad_f3 = (funct3 == 3'b011) || (funct3[2:1] == 2'b11) || (store && funct3[2]);
    case (funct3[1:0])
      2'b01:   misaligned = addr_lo[0];
      2'b10:   misaligned = (addr_lo != 2'b00);
      default: misaligned = 1'b0;
    endcase
    return bad_f3 || misaligned;
  endfunction

endpackage

// File: rtl/load_store_unit_checker.sv
// Protocol properties on the memory strobes of the load/store unit.
module load_store_unit_checker (
  input logic clk,
  input logic rst_n,
  input logic memRead,
  input logic memWrite
);

  // Read and write strobes are mutually exclusive
  a_strobe_excl: assert property (@(posedge clk) disable iff (!rst_n) !(memRead && memWrite))
    else $error("FAIL strobe_excl memRead and memWrite both high");

  // Each strobe lasts a single cycle
  a_read_pulse: assert property (@(posedge clk) disable iff (!rst_n) memRead |=> !memRead)
    else $error("FAIL read_pulse memRead high two cycles");

  a_write_pulse: assert property (@(posedge clk) disable iff (!rst_n) memWrite |=> !memWrite)
    else $error("FAIL write_pulse memWrite high two cycles");

endmodule

// File: rtl/load_store_unit_extend.sv
// Combinational sign/zero extension of the raw memory word according to the
// load funct3. The memory returns byte/half data right-aligned.
module load_extend
  import load_store_unit_pkg::*;
#(
  parameter int WORD_WIDTH = 32
) (
  input  logic [2:0]            funct3,
  input  logic [WORD_WIDTH-1:0] raw,
  output logic [WORD_WIDTH-1:0] ext
);

  // Select extension by access size and signedness
  always_comb begin
    ext = raw;
    case (funct3)
      F3_LB:   ext = {{(WORD_WIDTH-8){raw[7]}}, raw[7:0]};
      F3_LBU:  ext = {{(WORD_WIDTH-8){1'b0}}, raw[7:0]};
      F3_LH:   ext = {{(WORD_WIDTH-16){raw[15]}}, raw[15:0]};
      F3_LHU:  ext = {{(WORD_WIDTH-16){1'b0}}, raw[15:0]};
      F3_LW:   ext = raw;
      default: ext = raw;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Load/store initiator: accepts one request, validates it, issues a single
// one-cycle memory strobe, then returns an extended load result with done.
module load_store_unit
  import load_store_unit_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int WORD_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  reqValid,
  output logic                  reqReady,
  input  logic                  reqStore,
  input  logic [2:0]            reqFunct3,
  input  logic [ADDR_WIDTH-1:0] reqAddr,
  input  logic [WORD_WIDTH-1:0] reqWData,
  output logic                  done,
  output logic                  error,
  output logic [WORD_WIDTH-1:0] loadData,
  output logic                  memRead,
  output logic                  memWrite,
  output logic [1:0]            addrUnit,
  output logic [ADDR_WIDTH-1:0] memAddr,
  output logic [WORD_WIDTH-1:0] memWData,
  input  logic [WORD_WIDTH-1:0] memRData
);

  lsu_state_t            state_r;
  lsu_state_t            state_nxt_s;
  logic                  accept_s;
  logic                  req_err_s;
  logic                  store_r;
  logic [2:0]            funct3_r;
  logic [ADDR_WIDTH-1:0] addr_r;
  logic [WORD_WIDTH-1:0] wdata_r;
  logic                  err_r;
  logic [WORD_WIDTH-1:0] load_data_r;
  logic [WORD_WIDTH-1:0] ext_data_s;

  assign accept_s  = reqValid & (state_r == LSU_IDLE);
  assign req_err_s = lsu_req_error(reqStore, reqFunct3, reqAddr[1:0]);

  load_extend #(.WORD_WIDTH(WORD_WIDTH)) u_extend (
    .funct3 (funct3_r),
    .raw    (memRData),
    .ext    (ext_data_s)
  );

  // FSM state register; async reset abandons any in-flight request
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= LSU_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Latch the request fields and its legality at acceptance
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      store_r  <= 1'b0;
      funct3_r <= 3'b000;
      addr_r   <= '0;
      wdata_r  <= '0;
      err_r    <= 1'b0;
    end else if (accept_s) begin
      store_r  <= reqStore;
      funct3_r <= reqFunct3;
      addr_r   <= reqAddr;
      wdata_r  <= reqWData;
      err_r    <= req_err_s;
    end
  end

  // Memory data is only valid during CAPTURE; keep the extended value until the next load
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      load_data_r <= '0;
    end else if (state_r == LSU_CAPTURE) begin
      load_data_r <= ext_data_s;
    end
  end

  // Next-state: illegal requests skip the memory entirely, stores skip CAPTURE
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      LSU_IDLE: begin
        if (accept_s) begin
          state_nxt_s = req_err_s ? LSU_DONE : LSU_ACCESS;
        end else begin
          state_nxt_s = LSU_IDLE;
        end
      end
      LSU_ACCESS: begin
        if (store_r) begin
          state_nxt_s = LSU_DONE;
        end else begin
          state_nxt_s = LSU_CAPTURE;
        end
      end
      LSU_CAPTURE: state_nxt_s = LSU_DONE;
      LSU_DONE:    state_nxt_s = LSU_IDLE;
      default:     state_nxt_s = LSU_IDLE;
    endcase
  end

  // Outputs decoded from the registered state only
  always_comb begin
    reqReady = 1'b0;
    memRead  = 1'b0;
    memWrite = 1'b0;
    done     = 1'b0;
    error    = 1'b0;
    case (state_r)
      LSU_IDLE: reqReady = 1'b1;
      LSU_ACCESS: begin
        memRead  = ~store_r;
        memWrite = store_r;
      end
      LSU_CAPTURE: reqReady = 1'b0;
      LSU_DONE: begin
        done  = 1'b1;
        error = err_r;
      end
      default: reqReady = 1'b0;
    endcase
  end

  assign addrUnit = funct3_r[1:0];
  assign memAddr  = addr_r;
  assign memWData = wdata_r;
  assign loadData = load_data_r;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a byte memory model and a
// scoreboard of expected done results.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        reqValid;
  logic        reqReady;
  logic        reqStore;
  logic [2:0]  reqFunct3;
  logic [31:0] reqAddr;
  logic [31:0] reqWData;
  logic        done;
  logic        error;
  logic [31:0] loadData;
  logic        memRead;
  logic        memWrite;
  logic [1:0]  addrUnit;
  logic [31:0] memAddr;
  logic [31:0] memWData;
  logic [31:0] mem_rdata;

  logic [7:0]  mem [0:255];

  typedef struct {
    logic        err;
    logic [31:0] data;
  } sb_entry_t;
  sb_entry_t sb_q[$];

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  load_store_unit #(.ADDR_WIDTH(32), .WORD_WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .reqValid(reqValid), .reqReady(reqReady), .reqStore(reqStore),
    .reqFunct3(reqFunct3), .reqAddr(reqAddr), .reqWData(reqWData),
    .done(done), .error(error), .loadData(loadData),
    .memRead(memRead), .memWrite(memWrite), .addrUnit(addrUnit),
    .memAddr(memAddr), .memWData(memWData), .memRData(mem_rdata)
  );

  load_store_unit_checker u_chk (
    .clk(clk), .rst_n(rst_n), .memRead(memRead), .memWrite(memWrite)
  );

  // Synchronous little-endian byte memory; data valid one cycle after memRead, else 0
  always @(posedge clk) begin
    if (memWrite) begin
      case (addrUnit)
        2'b00: mem[memAddr[7:0]] <= memWData[7:0];
        2'b01: begin
          mem[memAddr[7:0]]         <= memWData[7:0];
          mem[memAddr[7:0] + 8'd1]  <= memWData[15:8];
        end
        default: begin
          mem[memAddr[7:0]]         <= memWData[7:0];
          mem[memAddr[7:0] + 8'd1]  <= memWData[15:8];
          mem[memAddr[7:0] + 8'd2]  <= memWData[23:16];
          mem[memAddr[7:0] + 8'd3]  <= memWData[31:24];
        end
      endcase
    end
    if (memRead) begin
      case (addrUnit)
        2'b00:   mem_rdata <= {24'h000000, mem[memAddr[7:0]]};
        2'b01:   mem_rdata <= {16'h0000, mem[memAddr[7:0] + 8'd1], mem[memAddr[7:0]]};
        default: mem_rdata <= {mem[memAddr[7:0] + 8'd3], mem[memAddr[7:0] + 8'd2],
                               mem[memAddr[7:0] + 8'd1], mem[memAddr[7:0]]};
      endcase
    end else begin
      mem_rdata <= 32'h0;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Scoreboard: every done pops the oldest expected result
  always @(negedge clk) begin
    if (rst_n === 1'b1 && done === 1'b1) begin
      if (sb_q.size() == 0) begin
        check("sb_spurious_done", 32'd1, 32'd0);
      end else begin
        sb_entry_t e;
        e = sb_q.pop_front();
        check("sb_error", {31'd0, error}, {31'd0, e.err});
        check("sb_loadData", loadData, e.data);
      end
    end
  end

  // One request: checks acceptance, latency, strobe count, size and address
  task automatic do_req(input string tag, input logic st, input logic [2:0] f3,
                        input logic [31:0] addr, input logic [31:0] wd,
                        input int exp_lat, input logic [1:0] exp_unit,
                        input logic exp_err, input logic [31:0] exp_data);
    int lat = 0;
    int rd = 0;
    int wr = 0;
    logic [1:0]  unit  = 2'b00;
    logic [31:0] maddr = 32'h0;
    logic [31:0] mwd   = 32'h0;
    sb_q.push_back('{exp_err, exp_data});
    @(negedge clk);
    check({tag, "_ready"}, {31'd0, reqReady}, 32'd1);
    reqValid = 1'b1; reqStore = st; reqFunct3 = f3; reqAddr = addr; reqWData = wd;
    for (int k = 1; k <= 8 && lat == 0; k++) begin
      @(negedge clk);
      if (memRead)  begin rd++; unit = addrUnit; maddr = memAddr; end
      if (memWrite) begin wr++; unit = addrUnit; maddr = memAddr; mwd = memWData; end
      if (done) lat = k;
      if (k == 1) reqValid = 1'b0;
    end
    check({tag, "_latency"}, lat, exp_lat);
    check({tag, "_rd_strobes"}, rd, (st || exp_err) ? 0 : 1);
    check({tag, "_wr_strobes"}, wr, (st && !exp_err) ? 1 : 0);
    if (!exp_err) begin
      check({tag, "_addrUnit"}, {30'd0, unit}, {30'd0, exp_unit});
      check({tag, "_memAddr"}, maddr, addr);
      if (st) check({tag, "_memWData"}, mwd, wd);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int acc[$];
    int dn[$];
    int done_cnt;

    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    mem[8'h10] = 8'h80; mem[8'h11] = 8'h7F; mem[8'h12] = 8'h34; mem[8'h13] = 8'h12;

    rst_n = 1'b0; reqValid = 1'b0; reqStore = 1'b0; reqFunct3 = 3'b000;
    reqAddr = 32'h0; reqWData = 32'h0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_reqReady", {31'd0, reqReady}, 32'd1);
    check("rst_done",     {31'd0, done},     32'd0);
    check("rst_error",    {31'd0, error},    32'd0);
    check("rst_memRead",  {31'd0, memRead},  32'd0);
    check("rst_memWrite", {31'd0, memWrite}, 32'd0);
    check("rst_loadData", loadData, 32'h0);
    check("rst_memAddr",  memAddr,  32'h0);
    check("rst_memWData", memWData, 32'h0);
    check("rst_addrUnit", {30'd0, addrUnit}, 32'd0);

    // Loads of every size from the initialised word
    do_req("lw_10",  1'b0, 3'b010, 32'h10, 32'h0, 3, 2'b10, 1'b0, 32'h12347F80);
    do_req("lb_10",  1'b0, 3'b000, 32'h10, 32'h0, 3, 2'b00, 1'b0, 32'hFFFFFF80);
    do_req("lbu_10", 1'b0, 3'b100, 32'h10, 32'h0, 3, 2'b00, 1'b0, 32'h00000080);
    do_req("lh_10",  1'b0, 3'b001, 32'h10, 32'h0, 3, 2'b01, 1'b0, 32'h00007F80);
    do_req("lhu_12", 1'b0, 3'b101, 32'h12, 32'h0, 3, 2'b01, 1'b0, 32'h00001234);

    // Store byte leaves loadData alone, then read it back
    do_req("sb_11",  1'b1, 3'b000, 32'h11, 32'hAABBCCDD, 2, 2'b00, 1'b0, 32'h00001234);
    do_req("lw_10b", 1'b0, 3'b010, 32'h10, 32'h0, 3, 2'b10, 1'b0, 32'h1234DD80);

    // Rejected requests: done+error in the first cycle, loadData held
    do_req("lw_12_mis",  1'b0, 3'b010, 32'h12, 32'h0, 1, 2'b00, 1'b1, 32'h1234DD80);
    do_req("sh_13_mis",  1'b1, 3'b001, 32'h13, 32'h5555, 1, 2'b00, 1'b1, 32'h1234DD80);
    do_req("ld_f3_011",  1'b0, 3'b011, 32'h10, 32'h0, 1, 2'b00, 1'b1, 32'h1234DD80);
    do_req("st_f3_100",  1'b1, 3'b100, 32'h10, 32'h0, 1, 2'b00, 1'b1, 32'h1234DD80);

    // reqValid held high across two loads
    sb_q.push_back('{1'b0, 32'h1234DD80});
    sb_q.push_back('{1'b0, 32'h1234DD80});
    @(negedge clk);
    reqValid = 1'b1; reqStore = 1'b0; reqFunct3 = 3'b010; reqAddr = 32'h10;
    for (int n = 0; n < 12; n++) begin
      if (n > 0) @(negedge clk);
      if (done) dn.push_back(n);
      if (reqValid && reqReady) acc.push_back(n);
      if (acc.size() == 2 && reqValid && n > acc[1]) reqValid = 1'b0;
    end
    check("b2b_accepts", acc.size(), 2);
    check("b2b_second_accept", (acc.size() > 1) ? acc[1] : -1, 4);
    check("b2b_dones", dn.size(), 2);
    check("b2b_first_done", (dn.size() > 0) ? dn[0] : -1, 3);
    check("b2b_second_done", (dn.size() > 1) ? dn[1] : -1, 7);

    // Async reset during ACCESS drops the strobe and loses the request
    @(negedge clk);
    reqValid = 1'b1; reqStore = 1'b0; reqFunct3 = 3'b010; reqAddr = 32'h10;
    @(posedge clk);
    #1;
    reqValid = 1'b0;
    check("rstmid_memRead_before", {31'd0, memRead}, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("rstmid_memRead_after", {31'd0, memRead}, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rstmid_reqReady", {31'd0, reqReady}, 32'd1);
    check("rstmid_loadData", loadData, 32'h0);
    done_cnt = 0;
    repeat (4) begin
      @(negedge clk);
      if (done) done_cnt++;
    end
    check("rstmid_no_done", done_cnt, 0);

    // Top byte of the word after reset
    do_req("lbu_13", 1'b0, 3'b100, 32'h13, 32'h0, 3, 2'b00, 1'b0, 32'h00000012);

    @(negedge clk);
    check("sb_empty", sb_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
